// File: rtl/axi_read_arbiter.sv
// N-master to 1-slave AXI3 read arbiter: round-robin grant, one burst in flight, response routed by ID.
// Optional statistics counters are enabled by defining AXI_READ_ARB_STAT_EN.
module axi_read_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned MAX_LEN     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_MASTERS-1:0]   m_arvalid,
  output logic [NUM_MASTERS-1:0]   m_arready,
  input  logic [NUM_MASTERS*32-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0] m_arlen,
  input  logic [NUM_MASTERS*3-1:0] m_arsize,
  output logic [NUM_MASTERS-1:0]   m_rvalid,
  input  logic [NUM_MASTERS-1:0]   m_rready,
  output logic [31:0]              m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [ID_WIDTH-1:0]      arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_WIDTH-1:0]      rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready
`ifdef AXI_READ_ARB_STAT_EN
  ,
  output logic [NUM_MASTERS*32-1:0] stat_grant_cnt,
  output logic [31:0]              stat_wait_cycles
`endif
);

  localparam int unsigned GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] gnt;
  logic [GW-1:0] sel;
  logic          sel_found;
  logic [7:0]    cnt;
  logic [7:0]    sel_len_raw;
  logic [7:0]    sel_len;
  logic          match;
  logic          beat;
  logic          burst_end;

  assign arburst = 2'b01;

  // Rotating search: first requester at or after the priority pointer.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel       = ptr;
    sel_found = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!sel_found && m_arvalid[idx]) begin
        sel_found = 1'b1;
        sel       = GW'(idx);
      end
    end
  end

  always_comb begin
    sel_len_raw = m_arlen[8*32'(sel) +: 8];
    sel_len     = (32'(sel_len_raw) > MAX_LEN - 1) ? 8'(MAX_LEN - 1) : sel_len_raw;
  end

  // A zero remaining-beat count terminates the burst even without rlast from the slave.
  always_comb begin
    m_rvalid = '0;
    rready   = 1'b0;
    m_rdata  = '0;
    m_rresp  = '0;
    m_rlast  = 1'b0;
    match    = (state == DATA) && (rid == ID_WIDTH'(gnt));
    if (state == DATA) begin
      m_rdata = rdata;
      m_rresp = rresp;
      m_rlast = rlast | (cnt == 8'd0);
      if (match) begin
        m_rvalid[gnt] = rvalid;
        rready        = m_rready[gnt];
      end
    end
    beat      = rvalid & rready;
    burst_end = rlast | (cnt == 8'd0);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      arvalid   <= 1'b0;
      m_arready <= '0;
      arid      <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
    end else begin
      m_arready <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt            <= sel;
            arid           <= ID_WIDTH'(sel);
            araddr         <= m_araddr[32*32'(sel) +: 32];
            arlen          <= sel_len;
            arsize         <= m_arsize[3*32'(sel) +: 3];
            m_arready[sel] <= 1'b1;
            arvalid        <= 1'b1;
            state          <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            cnt     <= arlen;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (burst_end) begin
              state <= IDLE;
              ptr   <= (gnt == GW'(NUM_MASTERS - 1)) ? '0 : gnt + 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_READ_ARB_STAT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_grant_cnt   <= '0;
      stat_wait_cycles <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (m_arready[i]) stat_grant_cnt[32*i +: 32] <= stat_grant_cnt[32*i +: 32] + 32'd1;
      end
      if ((|m_arvalid) && (state != IDLE)) stat_wait_cycles <= stat_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: transaction-level reference model compared every cycle,
// plus directed bursts with literal expectations.
module tb_axi_read_arbiter;
  localparam int NM  = 3;
  localparam int IDW = 4;
  localparam int ML  = 16;

  logic              aclk;
  logic              aresetn;
  logic [NM-1:0]     m_arvalid;
  logic [NM-1:0]     m_arready;
  logic [NM*32-1:0]  m_araddr;
  logic [NM*8-1:0]   m_arlen;
  logic [NM*3-1:0]   m_arsize;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [IDW-1:0]    arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [IDW-1:0]    rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
`ifdef AXI_READ_ARB_STAT_EN
  logic [NM*32-1:0]  stat_grant_cnt;
  logic [31:0]       stat_wait_cycles;
`endif

  axi_read_arbiter #(.NUM_MASTERS(NM), .ID_WIDTH(IDW), .MAX_LEN(ML)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
`ifdef AXI_READ_ARB_STAT_EN
    , .stat_grant_cnt(stat_grant_cnt), .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one owned burst at a time, described by owner, AR-accepted flag and beats delivered.
  bit          owned, ar_done, pulse;
  int unsigned mp_ptr, cur, beats;
  logic [31:0] e_addr;
  logic [7:0]  e_len;
  logic [2:0]  e_size;
  int unsigned gcnt [NM];
  int unsigned wcnt;

  always @(posedge aclk) begin
    int unsigned i;
    if (!aresetn) begin
      owned = 0; ar_done = 0; pulse = 0; mp_ptr = 0; cur = 0; beats = 0;
      e_addr = '0; e_len = '0; e_size = '0; wcnt = 0;
      for (int k = 0; k < NM; k++) gcnt[k] = 0;
    end else begin
      if (pulse) gcnt[cur]++;
      if ((|m_arvalid) && owned) wcnt++;
      pulse = 0;
      if (!owned) begin
        for (int k = 0; k < NM; k++) begin
          i = (mp_ptr + k) % NM;
          if (!owned && m_arvalid[i]) begin
            owned = 1;
            cur   = i;
          end
        end
        if (owned) begin
          pulse   = 1;
          ar_done = 0;
          e_addr  = m_araddr[32*cur +: 32];
          e_len   = (int'(m_arlen[8*cur +: 8]) > ML - 1) ? 8'(ML - 1) : m_arlen[8*cur +: 8];
          e_size  = m_arsize[3*cur +: 3];
        end
      end else if (!ar_done) begin
        if (arready) begin
          ar_done = 1;
          beats   = 0;
        end
      end else if (rvalid && int'(rid) == int'(cur) && m_rready[cur]) begin
        beats++;
        if (rlast || beats == int'(e_len) + 1) begin
          owned  = 0;
          mp_ptr = (cur + 1) % NM;
        end
      end
    end
  end

  always @(negedge aclk) begin
    bit          data, mt;
    logic [63:0] oh;
    if (checking) begin
      data = owned && ar_done;
      mt   = data && (int'(rid) == int'(cur));
      oh   = 64'(1) << cur;
      chk("m_arready", 64'(m_arready), pulse ? oh : 64'(0));
      chk("arvalid", 64'(arvalid), 64'(owned && !ar_done));
      chk("arid", 64'(arid), 64'(cur));
      chk("araddr", 64'(araddr), 64'(e_addr));
      chk("arlen", 64'(arlen), 64'(e_len));
      chk("arsize", 64'(arsize), 64'(e_size));
      chk("arburst", 64'(arburst), 64'(1));
      chk("rready", 64'(rready), 64'(mt && m_rready[cur]));
      chk("m_rvalid", 64'(m_rvalid), (mt && rvalid) ? oh : 64'(0));
      chk("m_rdata", 64'(m_rdata), data ? 64'(rdata) : 64'(0));
      chk("m_rresp", 64'(m_rresp), data ? 64'(rresp) : 64'(0));
      chk("m_rlast", 64'(m_rlast), 64'(data && (rlast || beats == int'(e_len))));
`ifdef AXI_READ_ARB_STAT_EN
      for (int k = 0; k < NM; k++) chk("stat_grant_cnt", 64'(stat_grant_cnt[32*k +: 32]), 64'(gcnt[k]));
      chk("stat_wait_cycles", 64'(stat_wait_cycles), 64'(wcnt));
`endif
    end
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz);
    m_araddr[32*m +: 32] = a;
    m_arlen[8*m +: 8]    = len;
    m_arsize[3*m +: 3]   = sz;
    m_arvalid[m]         = 1'b1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; m_arvalid = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0;
    step(); step();
    aresetn = 1'b1;
  endtask

  // Drives the slave side of one burst for master m; rlast_idx < 0 means the slave never raises rlast.
  task automatic serve(input int m, input int nbeats, input int rlast_idx, input int ar_delay,
                       input int bad_rid, input bit stall, input bit keep);
    int          t;
    logic [31:0] a0;
    logic [63:0] oh;
    oh = 64'(1) << m;
    t  = 0;
    while (!arvalid && t < 20) begin step(); t++; end
    chk("arvalid_seen", 64'(arvalid), 64'(1));
    chk("arid_lit", 64'(arid), 64'(m));
    chk("m_arready_lit", 64'(m_arready), oh);
    a0 = araddr;
    arready = (ar_delay == 0);
    step();
    if (!keep) m_arvalid[m] = 1'b0;
    if (ar_delay > 0) begin
      repeat (ar_delay - 1) begin
        chk("ar_hold_valid", 64'(arvalid), 64'(1));
        chk("ar_hold_addr", 64'(araddr), 64'(a0));
        chk("ar_no_pulse", 64'(m_arready), 64'(0));
        step();
      end
      arready = 1'b1;
      step();
    end
    arready = 1'b0;
    for (int c = 0; c < bad_rid; c++) begin
      rvalid = 1'b1; rid = IDW'((m + 2) % NM); rdata = $urandom; rlast = 1'b1;
      #1;
      chk("bad_rid_rready", 64'(rready), 64'(0));
      chk("bad_rid_rvalid", 64'(m_rvalid), 64'(0));
      step();
    end
    if (stall) begin
      rvalid = 1'b1; rid = IDW'(m); rlast = 1'b0; m_rready[m] = 1'b0;
      #1;
      chk("stall_rready", 64'(rready), 64'(0));
      step();
      m_rready[m] = 1'b1;
    end
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1; rid = IDW'(m); rdata = 32'hA5000000 + 32'(b); rresp = 2'(b);
      rlast = (b == rlast_idx);
      #1;
      chk("beat_rvalid", 64'(m_rvalid), oh);
      chk("beat_rlast", 64'(m_rlast), 64'(b == nbeats - 1));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    aresetn = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
    m_rready = '1; arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    step(); step();
    aresetn = 1'b1;
    checking = 1;
    chk("reset_arvalid", 64'(arvalid), 64'(0));
    chk("reset_araddr", 64'(araddr), 64'(0));

    // Single request from master 1.
    set_req(1, 32'h1FC00000, 8'd3, 3'd2);
    serve(1, 4, 3, 0, 0, 0, 0);
    chk("t1_araddr", 64'(araddr), 64'h1FC00000);
    chk("t1_arlen", 64'(arlen), 64'(3));
    chk("t1_arburst", 64'(arburst), 64'(1));
    repeat (3) step();
    chk("t1_idle_arvalid", 64'(arvalid), 64'(0));

    // All three from reset: order 0,1,2,0; clamp, forced last and early last along the way.
    do_reset();
    set_req(0, 32'h00001000, 8'd3, 3'd2);
    set_req(1, 32'h00002000, 8'd20, 3'd2);
    set_req(2, 32'h00003000, 8'd1, 3'd1);
    serve(0, 4, 3, 0, 0, 0, 1);
    serve(1, 16, 15, 2, 0, 0, 0);
    chk("clamp_arlen", 64'(arlen), 64'(15));
    serve(2, 2, -1, 0, 0, 0, 0);
    serve(0, 2, 1, 0, 0, 0, 0);
    chk("t2_idle_arvalid", 64'(arvalid), 64'(0));

    // Long arready stall; master 2 requests briefly while busy and withdraws.
    set_req(1, 32'h80000100, 8'd0, 3'd2);
    fork
      serve(1, 1, 0, 10, 0, 0, 0);
      begin
        repeat (4) step();
        m_arvalid[2] = 1'b1;
        step();
        m_arvalid[2] = 1'b0;
      end
    join
    repeat (4) step();
    chk("withdrawn_not_granted", 64'(arvalid), 64'(0));

    // Mismatching rid stalls, then normal completion with one backpressure cycle.
    set_req(0, 32'h00004000, 8'd2, 3'd2);
    serve(0, 3, 2, 0, 3, 1, 0);

    // Reset in the middle of a four-beat burst.
    set_req(1, 32'h00005000, 8'd3, 3'd2);
    t = 0;
    while (!arvalid && t < 20) begin step(); t++; end
    chk("t5_arvalid", 64'(arvalid), 64'(1));
    arready = 1'b1;
    step();
    m_arvalid[1] = 1'b0; arready = 1'b0;
    rvalid = 1'b1; rid = IDW'(1); rlast = 1'b0; rdata = 32'h12345678; rresp = 2'd1;
    step();
    aresetn = 1'b0;
    step();
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_m_rvalid", 64'(m_rvalid), 64'(0));
    chk("rst_m_rdata", 64'(m_rdata), 64'(0));
    chk("rst_m_rlast", 64'(m_rlast), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_arlen", 64'(arlen), 64'(0));
    aresetn = 1'b1; rvalid = 1'b0; rid = '0;
    set_req(2, 32'h00006000, 8'd1, 3'd2);
    serve(2, 2, 1, 0, 0, 0, 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
